// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM encoding, owner ids, default widths.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic OWNER_M0 = 1'b0;
  localparam logic OWNER_M1 = 1'b1;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational two-way picker. DMEM_ARB_RR_EN selects round-robin on ties;
// without it requester 0 has fixed priority.
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic gnt0,
  output logic gnt1,
  output logic winner
);

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    winner = OWNER_M0;
    if (req0 && req1)
      winner = (last_owner == OWNER_M0) ? OWNER_M1 : OWNER_M0;
    else if (req1)
      winner = OWNER_M1;
  end
`else
  // Fixed priority ignores history; the input is kept so both builds share one port list.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = OWNER_M0;
    if (!req0 && req1)
      winner = OWNER_M1;
  end
`endif

  assign gnt0 = req0 && (winner == OWNER_M0);
  assign gnt1 = req1 && (winner == OWNER_M1);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares single-port Data_Memory between two word requesters (IDLE -> ACCESS -> RESP).
// Build option: DMEM_ARB_RR_EN enables round-robin tie breaking in the picker.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_WE,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  input  logic [DATA_W-1:0] mem_RD
);

  state_t              state;
  logic                owner;
  logic                last_owner;
  logic                acc_we;
  logic [ADDR_W-1:0]   acc_addr;
  logic [DATA_W-1:0]   acc_wdata;

  logic pick_gnt0, pick_gnt1, pick_winner;
  logic can_grant, any_gnt, in_access, aligned;

  dmem_arb_pick u_pick (
    .req0       (m0_req),
    .req1       (m1_req),
    .last_owner (last_owner),
    .gnt0       (pick_gnt0),
    .gnt1       (pick_gnt1),
    .winner     (pick_winner)
  );

  // Grants only in IDLE/RESP; reset masks them so nothing is accepted while rst is high.
  assign can_grant = (state != ACCESS) && !rst;
  assign m0_gnt    = can_grant && pick_gnt0;
  assign m1_gnt    = can_grant && pick_gnt1;
  assign any_gnt   = m0_gnt || m1_gnt;

  assign aligned   = word_aligned(acc_addr[1:0]);
  assign in_access = (state == ACCESS) && !rst;
  assign mem_WE    = in_access && acc_we && aligned;
  assign mem_A     = in_access ? acc_addr  : '0;
  assign mem_WD    = in_access ? acc_wdata : '0;

  always_ff @(posedge clk) begin
    if (any_gnt) begin
      acc_we    <= (pick_winner == OWNER_M1) ? m1_we    : m0_we;
      acc_addr  <= (pick_winner == OWNER_M1) ? m1_addr  : m0_addr;
      acc_wdata <= (pick_winner == OWNER_M1) ? m1_wdata : m0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWNER_M0;
      last_owner <= OWNER_M1;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (any_gnt) begin
            owner <= pick_winner;
            state <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          last_owner <= owner;
          // Misaligned or write accesses return zero data.
          if (owner == OWNER_M1) begin
            m1_rvalid <= 1'b1;
            m1_err    <= !aligned;
            m1_rdata  <= (!acc_we && aligned) ? mem_RD : '0;
          end else begin
            m0_rvalid <= 1'b1;
            m0_err    <= !aligned;
            m0_rdata  <= (!acc_we && aligned) ? mem_RD : '0;
          end
          state <= RESP;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural word memory behind the memory port.
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              mem_WE;
  logic [ADDR_W-1:0] mem_A;
  logic [DATA_W-1:0] mem_WD, mem_RD;

  logic [DATA_W-1:0] mem [0:255];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_WE(mem_WE), .mem_A(mem_A), .mem_WD(mem_WD), .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A[9:2]];
  always @(posedge clk) if (mem_WE) mem[mem_A[9:2]] <= mem_WD;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  // One transaction on port p; checks grant, memory strobe, response and the idle port.
  task automatic txn(input int p, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [31:0] exp_rdata, input logic exp_err, input string tag);
    logic got;
    cyc();
    if (p == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    else        begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    got = 0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      got = (p == 0) ? m0_gnt : m1_gnt;
      if (!got) cyc();
    end
    chk({tag, "_gnt"}, got, 1'b1);
    cyc();
    m0_req = 0; m1_req = 0;
    @(negedge clk);
    chk({tag, "_we"}, mem_WE, we && (addr[1:0] == 2'b00));
    chk({tag, "_addr"}, mem_A, addr);
    chk({tag, "_gnt_acc"}, {m0_gnt, m1_gnt}, 2'b00);
    cyc();
    @(negedge clk);
    chk({tag, "_rvalid"}, (p == 0) ? {m0_rvalid, m1_rvalid} : {m1_rvalid, m0_rvalid}, 2'b10);
    chk({tag, "_err"}, (p == 0) ? m0_err : m1_err, exp_err);
    chk({tag, "_rdata"}, (p == 0) ? m0_rdata : m1_rdata, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i;
    rst = 1; m0_req = 1; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;

    cyc(); cyc();
    @(negedge clk);
    chk("rst_gnt", {m0_gnt, m1_gnt}, 2'b00);
    chk("rst_rvalid", {m0_rvalid, m1_rvalid, m0_err, m1_err}, 4'b0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'h0);
    chk("rst_mem", {mem_WE, mem_A}, 33'h0);
    chk("rst_wd", mem_WD, 32'h0);
    m0_req = 0;
    cyc();
    rst = 0;

    // Aligned write then read back, m1 read alone, misaligned write.
    txn(0, 1, 32'h08, 32'h0000_000A, 32'h0, 1'b0, "wr08");
    txn(0, 0, 32'h08, 32'h0,         32'h0000_000A, 1'b0, "rd08");
    txn(1, 0, 32'h04, 32'h0,         32'h1000_0001, 1'b0, "m1rd04");
    txn(0, 1, 32'h06, 32'hDEAD_BEEF, 32'h0, 1'b1, "wr06");
    txn(0, 0, 32'h04, 32'h0,         32'h1000_0001, 1'b0, "rd04");
    chk("mem1_kept", mem[1], 32'h1000_0001);

    // Back-to-back reads with req held.
    for (int c = 0; c <= 6; c++) begin
      cyc();
      m0_req = (c <= 4); m0_we = 0; m0_addr = 32'((c / 2) * 4);
      @(negedge clk);
      chk($sformatf("b2b_gnt%0d", c), m0_gnt, (c % 2 == 0) && (c <= 4));
      chk($sformatf("b2b_rv%0d", c), m0_rvalid, (c >= 2) && (c % 2 == 0));
      if (c == 2) chk("b2b_rd0", m0_rdata, 32'h1000_0000);
      if (c == 4) chk("b2b_rd1", m0_rdata, 32'h1000_0001);
      if (c == 6) chk("b2b_rd2", m0_rdata, 32'h0000_000A);
    end

    // Reset sampled during ACCESS of an m1 write.
    cyc();
    m1_req = 1; m1_we = 1; m1_addr = 32'h0C; m1_wdata = 32'h5555_5555;
    @(negedge clk);
    chk("rstacc_gnt", m1_gnt, 1'b1);
    cyc();
    m1_req = 0; rst = 1;
    @(negedge clk);
    chk("rstacc_we", mem_WE, 1'b0);
    cyc();
    rst = 0;
    @(negedge clk);
    chk("rstacc_rv", {m0_rvalid, m1_rvalid}, 2'b00);
    chk("rstacc_mem", mem[3], 32'h1000_0003);
    txn(1, 0, 32'h0C, 32'h0, 32'h1000_0003, 1'b0, "rd0C");

    // Fresh reset, then both requesters contend continuously.
    cyc(); rst = 1;
    cyc(); rst = 0;
    for (int c = 0; c <= 7; c++) begin
      logic e0, e1;
      cyc();
      m0_req = (c < 7); m0_we = 0; m0_addr = 32'h10;
      m1_req = (c < 7); m1_we = 0; m1_addr = 32'h14;
`ifdef DMEM_ARB_RR_EN
      e0 = (c % 4 == 0);
      e1 = (c % 4 == 2);
`else
      e0 = (c % 2 == 0) && (c < 7);
      e1 = 1'b0;
`endif
      @(negedge clk);
      chk($sformatf("tie_g0_%0d", c), m0_gnt, e0);
      chk($sformatf("tie_g1_%0d", c), m1_gnt, e1);
      if (c == 2) chk("tie_rd0", m0_rdata, 32'h1000_0004);
    end
    cyc(); cyc(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter/sequencer that shares the single-port Data_Memory between requester 0 (CPU load/store path) and requester 1 (DMA/debug loader). It accepts word requests over a req/gnt handshake, drives the memory's WE/A/WD for exactly one access cycle, and returns registered read data with a one-cycle rvalid pulse. It sits between the core/DMA and Data_Memory in the top level.

Parameters:
- ADDR_W, 32, address width of requesters and memory
- DATA_W, 32, data word width

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  requester 0 request; held with its fields stable until m0_gnt
- m0_we  in  1  requester 0 write (1) / read (0)
- m0_addr  in  ADDR_W  requester 0 byte address
- m0_wdata  in  DATA_W  requester 0 write data
- m0_gnt  out  1  request accepted this cycle (combinational)
- m0_rvalid  out  1  one-cycle completion pulse (reads and writes)
- m0_rdata  out  DATA_W  read data, valid when m0_rvalid
- m0_err  out  1  misaligned access flag, valid with m0_rvalid
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as m0 for requester 1
- mem_WE  out  1  to Data_Memory WE
- mem_A  out  ADDR_W  to Data_Memory A
- mem_WD  out  DATA_W  to Data_Memory WD
- mem_RD  in  DATA_W  from Data_Memory RD (combinational read)

Behaviour:
- States: IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: all gnt/rvalid/err = 0, rdata = 0, mem_WE = 0, mem_A = 0, mem_WD = 0, owner = 0, last_owner = 1.
- IDLE/RESP: if any req, picker selects winner; winner's gnt = 1 same cycle; at edge latch owner, we, addr, wdata; next state ACCESS. No req: RESP -> IDLE, IDLE stays.
- ACCESS: mem_A = latched addr, mem_WD = latched wdata, mem_WE = latched we AND addr[1:0]==0; write commits at this edge. Owner's rdata register <= mem_RD if read and aligned, else 0. last_owner <= owner. Next RESP.
- RESP: owner's rvalid = 1 for this cycle; err = 1 if latched addr[1:0] != 0 (misaligned: no write, rdata 0). New grant may occur in RESP (back-to-back).
- Throughput: one transaction per 2 cycles; latency gnt -> rvalid = 2 cycles.
- mem_WE is 1 only in ACCESS; in IDLE/RESP mem_A/mem_WD = 0.
- gnt never asserted in ACCESS; at most one gnt per cycle.
- rdata of the non-owner port holds its previous value.
- Reset mid-transaction: in-flight access dropped, no rvalid, no write if reset sampled in ACCESS cycle (mem_WE forced 0 while rst=1).

Optional Feature:
- Macro DMEM_ARB_RR_EN. Defined: round-robin; on simultaneous req the port != last_owner wins (m0 wins first tie after reset). Undefined: fixed priority, m0 always wins; last_owner still tracked but unused.

Decomposition:
- Package dmem_arb_pkg: state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2), OWNER_M0/OWNER_M1 constants, ADDR_W/DATA_W defaults.
- Sub-module dmem_arb_pick: combinational picker (req0, req1, last_owner -> gnt0, gnt1, winner); holds the macro-dependent logic.

Test Plan:
- Reset then m0 write addr 0x08 data 0x0000000A -> m0_gnt in cycle 0, mem_WE=1 with mem_A=0x08 in cycle 1, m0_rvalid=1 err=0 in cycle 2; m0 read 0x08 -> m0_rdata=0x0000000A.
- m1 read 0x04 alone -> m1_gnt, m1_rvalid 2 cycles later, m0_rvalid stays 0.
- m0 and m1 req together continuously, RR_EN defined -> grants alternate m0,m1,m0,m1 every 2 cycles; undefined -> m0 granted every time, m1 starved.
- m0 write to 0x06 -> mem_WE stays 0, m0_rvalid=1 with m0_err=1, m0_rdata=0; subsequent read of 0x04 unchanged.
- rst=1 asserted during ACCESS of m1 write to 0x0C -> mem_WE=0, no m1_rvalid, state IDLE; read 0x0C afterwards returns old value.
- Back-to-back: m0 holds req for 3 reads 0x00,0x04,0x08 -> gnt in cycles 0,2,4; rvalid in cycles 2,4,6.
